// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode constants, decoded-instruction record and decode helpers
package decode_pkg;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic        valid;
      logic        rtype;
      logic        itype;
      logic        lui;
      logic        auipc;
      logic        load;
      logic        store;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        illegal;
      logic [2:0]  funct3;
      logic [31:0] imm;
      logic [31:0] final_i;
      logic [31:0] final_pc;
      logic [4:0]  reg1;
      logic [4:0]  reg2;
      logic [4:0]  reg_d;
      logic        uses_rs1;
      logic        uses_rs2;
   } dec_t;

   // Immediate extraction by opcode format; R-type and unknown opcodes carry no immediate.
   function automatic logic [31:0] imm_decode(input logic [31:0] inst);
      logic [31:0] imm;
      case (inst[6:0])
         OP_I, OP_LOAD, OP_JALR: imm = {{20{inst[31]}}, inst[31:20]};
         OP_STORE:               imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OP_BRANCH:              imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OP_JAL:                 imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         OP_LUI, OP_AUIPC:       imm = {inst[31:12], 12'b0};
         default:                imm = 32'b0;
      endcase
      return imm;
   endfunction

   // Full decode of one queued instruction; register fields not used by the format are zeroed.
   function automatic dec_t decode_inst(input logic [31:0] inst, input logic [31:0] pc);
      dec_t d;
      logic has_rd;
      d          = '0;
      d.valid    = 1'b1;
      d.funct3   = inst[14:12];
      d.final_i  = inst;
      d.final_pc = pc;
      d.imm      = imm_decode(inst);
      case (inst[6:0])
         OP_R:      begin d.rtype  = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         OP_I:      begin d.itype  = 1'b1; d.uses_rs1 = 1'b1; end
         OP_LOAD:   begin d.load   = 1'b1; d.uses_rs1 = 1'b1; end
         OP_STORE:  begin d.store  = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         OP_BRANCH: begin d.branch = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; end
         OP_JAL:    d.jal   = 1'b1;
         OP_JALR:   begin d.jalr   = 1'b1; d.uses_rs1 = 1'b1; end
         OP_LUI:    d.lui   = 1'b1;
         OP_AUIPC:  d.auipc = 1'b1;
         default:   d.illegal = 1'b1;
      endcase
      has_rd  = d.rtype | d.itype | d.load | d.jal | d.jalr | d.lui | d.auipc;
      d.reg1  = d.uses_rs1 ? inst[19:15] : 5'd0;
      d.reg2  = d.uses_rs2 ? inst[24:20] : 5'd0;
      d.reg_d = has_rd ? inst[11:7] : 5'd0;
      return d;
   endfunction

   // Bubble presented when nothing is decoded: an I-type NOP that is not valid.
   function automatic dec_t bubble(input logic [31:0] nop);
      dec_t d;
      d         = '0;
      d.itype   = 1'b1;
      d.final_i = nop;
      return d;
   endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular FIFO holding fetched {inst, pc} entries
module inst_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rptr;
   logic [AW-1:0]    wptr;

   assign rdata = mem[rptr];

   // Storage write; pointer reset makes stale contents unreachable, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wdata;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; clear empties the queue in one edge.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/decode_iq.sv
// rtl/decode_iq.sv - instruction queue plus registered decode stage
module decode_iq
   import decode_pkg::*;
#(
   parameter int          IQ_DEPTH = 4,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        f_valid,
   input  logic [31:0] f_inst,
   input  logic [31:0] f_pc,
   output logic        f_ready,
   output logic [4:0]  file_reg1,
   output logic [4:0]  file_reg2,
   input  logic [31:0] file_val1,
   input  logic [31:0] file_val2,
   output logic        d_valid,
   output logic        rtype,
   output logic        itype,
   output logic        lui,
   output logic        auipc,
   output logic        load,
   output logic        store,
   output logic        branch,
   output logic        jal,
   output logic        jalr,
   output logic        illegal,
   output logic [2:0]  funct3,
   output logic [31:0] imm,
   output logic [31:0] finalI,
   output logic [31:0] finalpc,
   output logic [4:0]  reg1,
   output logic [4:0]  reg2,
   output logic [4:0]  regD,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic [31:0] reg1val,
   output logic [31:0] reg2val
);

   localparam int CW = $clog2(IQ_DEPTH+1);

   logic [CW-1:0] count;
   logic [63:0]   head;
   logic          push;
   logic          pop;
   dec_t          dec;
   dec_t          out_q;

   assign f_ready = (count < CW'(IQ_DEPTH));
   assign push    = f_valid && f_ready && !flush;
   assign pop     = !stall && !flush && (count != '0);
   assign dec     = decode_inst(head[63:32], head[31:0]);

   inst_queue #(.DEPTH(IQ_DEPTH), .WIDTH(64)) u_queue (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push),
      .wdata ({f_inst, f_pc}),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   // Register-file read addresses follow whichever instruction will own reg1val/reg2val next.
   always_comb begin
      file_reg1 = 5'd0;
      file_reg2 = 5'd0;
      if (pop) begin
         file_reg1 = dec.reg1;
         file_reg2 = dec.reg2;
      end else if (stall && !flush) begin
         file_reg1 = out_q.reg1;
         file_reg2 = out_q.reg2;
      end
   end

   // Output stage: reset/flush bubble, stall holds decode but refreshes operands, else load head or bubble.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_q   <= bubble(NOP_INST);
         reg1val <= '0;
         reg2val <= '0;
      end else if (stall) begin
         reg1val <= file_val1;
         reg2val <= file_val2;
      end else if (pop) begin
         out_q   <= dec;
         reg1val <= file_val1;
         reg2val <= file_val2;
      end else begin
         out_q   <= bubble(NOP_INST);
         reg1val <= '0;
         reg2val <= '0;
      end
   end

   assign d_valid  = out_q.valid;
   assign rtype    = out_q.rtype;
   assign itype    = out_q.itype;
   assign lui      = out_q.lui;
   assign auipc    = out_q.auipc;
   assign load     = out_q.load;
   assign store    = out_q.store;
   assign branch   = out_q.branch;
   assign jal      = out_q.jal;
   assign jalr     = out_q.jalr;
   assign illegal  = out_q.illegal;
   assign funct3   = out_q.funct3;
   assign imm      = out_q.imm;
   assign finalI   = out_q.final_i;
   assign finalpc  = out_q.final_pc;
   assign reg1     = out_q.reg1;
   assign reg2     = out_q.reg2;
   assign regD     = out_q.reg_d;
   assign uses_rs1 = out_q.uses_rs1;
   assign uses_rs2 = out_q.uses_rs2;

endmodule

// File: tb/tb_decode_iq.sv
// tb/tb_decode_iq.sv - scoreboard bench for decode_iq against a behavioural decode model
module tb_decode_iq;

   localparam int DEPTH = 4;
   localparam int K_NONE = 0, K_NEW = 1, K_HOLD = 2, K_BUB = 3;

   logic        clk, rst, stall, flush, f_valid, f_ready;
   logic [31:0] f_inst, f_pc, file_val1, file_val2;
   logic [4:0]  file_reg1, file_reg2;
   logic        d_valid, rtype, itype, lui, auipc, load, store, branch, jal, jalr, illegal;
   logic [2:0]  funct3;
   logic [31:0] imm, finalI, finalpc, reg1val, reg2val;
   logic [4:0]  reg1, reg2, regD;
   logic        uses_rs1, uses_rs2;

   logic        ovr1_en;
   logic [31:0] ovr1;

   typedef struct packed {
      bit        dv;
      bit [9:0]  cls;   // {rtype,itype,lui,auipc,load,store,branch,jal,jalr,illegal}
      bit [2:0]  f3;
      bit [31:0] imm;
      bit [31:0] fi;
      bit [31:0] fpc;
      bit [4:0]  r1;
      bit [4:0]  r2;
      bit [4:0]  rd;
      bit        u1;
      bit        u2;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        last;
   int          kind = K_NONE;
   bit [31:0]   rv1, rv2;
   int          n_cmp = 0;
   int          n_err = 0;

   decode_iq #(.IQ_DEPTH(DEPTH), .NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .f_valid(f_valid), .f_inst(f_inst), .f_pc(f_pc), .f_ready(f_ready),
      .file_reg1(file_reg1), .file_reg2(file_reg2), .file_val1(file_val1), .file_val2(file_val2),
      .d_valid(d_valid), .rtype(rtype), .itype(itype), .lui(lui), .auipc(auipc), .load(load),
      .store(store), .branch(branch), .jal(jal), .jalr(jalr), .illegal(illegal),
      .funct3(funct3), .imm(imm), .finalI(finalI), .finalpc(finalpc),
      .reg1(reg1), .reg2(reg2), .regD(regD), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
      .reg1val(reg1val), .reg2val(reg2val)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit [31:0] rf(input bit [4:0] a);
      return (a == 5'd0) ? 32'd0 : 32'h1000_0000 + 32'(a) * 32'd17;
   endfunction

   assign file_val1 = ovr1_en ? ovr1 : rf(file_reg1);
   assign file_val2 = rf(file_reg2);

   // Reference decode: classify by opcode, build immediates arithmetically from bit weights.
   function automatic exp_t ref_decode(input bit [31:0] inst, input bit [31:0] pc);
      exp_t   e;
      longint sv;
      int     k;
      bit     has_rd;
      e = '0; sv = 0; has_rd = 0;
      e.dv = 1; e.f3 = inst[14:12]; e.fi = inst; e.fpc = pc;
      case (inst[6:0])
         7'h33: begin k = 9; e.u1 = 1; e.u2 = 1; has_rd = 1; end
         7'h13: begin k = 8; e.u1 = 1; has_rd = 1; sv = inst[31:20]; if (sv >= 2048) sv -= 4096; end
         7'h37: begin k = 7; has_rd = 1; sv = longint'(inst[31:12]) * 4096; end
         7'h17: begin k = 6; has_rd = 1; sv = longint'(inst[31:12]) * 4096; end
         7'h03: begin k = 5; e.u1 = 1; has_rd = 1; sv = inst[31:20]; if (sv >= 2048) sv -= 4096; end
         7'h23: begin k = 4; e.u1 = 1; e.u2 = 1;
                   sv = longint'(inst[31:25]) * 32 + inst[11:7]; if (sv >= 2048) sv -= 4096; end
         7'h63: begin k = 3; e.u1 = 1; e.u2 = 1;
                   sv = longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
                   if (inst[31]) sv -= 4096; end
         7'h6F: begin k = 2; has_rd = 1;
                   sv = longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
                   if (inst[31]) sv -= 1048576; end
         7'h67: begin k = 1; e.u1 = 1; has_rd = 1; sv = inst[31:20]; if (sv >= 2048) sv -= 4096; end
         default: k = 0;
      endcase
      e.cls = 10'd1 << k;
      e.imm = sv[31:0];
      e.r1  = e.u1 ? inst[19:15] : 5'd0;
      e.r2  = e.u2 ? inst[24:20] : 5'd0;
      e.rd  = has_rd ? inst[11:7] : 5'd0;
      return e;
   endfunction

   function automatic exp_t bubble_exp();
      exp_t e;
      e = '0;
      e.cls = 10'b01_0000_0000;
      e.fi  = 32'h0000_0013;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_out(input string tag, input exp_t e, input bit [31:0] v1, input bit [31:0] v2);
      chk({tag, ".d_valid"}, 32'(d_valid), 32'(e.dv));
      chk({tag, ".class"}, 32'({rtype, itype, lui, auipc, load, store, branch, jal, jalr, illegal}), 32'(e.cls));
      chk({tag, ".funct3"}, 32'(funct3), 32'(e.f3));
      chk({tag, ".imm"}, imm, e.imm);
      chk({tag, ".finalI"}, finalI, e.fi);
      chk({tag, ".finalpc"}, finalpc, e.fpc);
      chk({tag, ".regs"}, 32'({reg1, reg2, regD}), 32'({e.r1, e.r2, e.rd}));
      chk({tag, ".uses"}, 32'({uses_rs1, uses_rs2}), 32'({e.u1, e.u2}));
      chk({tag, ".reg1val"}, reg1val, v1);
      chk({tag, ".reg2val"}, reg2val, v2);
   endtask

   // Model of each edge: decide what the output stage should do and record accepted pushes.
   always @(posedge clk) begin
      if (rst || flush) begin
         exp_q.delete();
         kind = K_BUB; rv1 = 0; rv2 = 0;
      end else begin
         if (stall) begin
            kind = K_HOLD;
            rv1 = ovr1_en ? ovr1 : rf(last.r1);
            rv2 = rf(last.r2);
         end else if (exp_q.size() > 0) begin
            kind = K_NEW;
            rv1 = ovr1_en ? ovr1 : rf(exp_q[0].r1);
            rv2 = rf(exp_q[0].r2);
         end else begin
            kind = K_BUB; rv1 = 0; rv2 = 0;
         end
         if (f_valid && exp_q.size() < DEPTH) exp_q.push_back(ref_decode(f_inst, f_pc));
      end
   end

   // Monitor: on the falling edge compare the presented outputs with the scoreboard.
   always @(negedge clk) begin
      if (kind != K_NONE) begin
         case (kind)
            K_NEW: begin
               if (exp_q.size() == 0) begin
                  chk("sb_underflow", 32'd1, 32'd0);
               end else begin
                  last = exp_q.pop_front();
                  check_out("new", last, rv1, rv2);
               end
            end
            K_HOLD: check_out("hold", last, rv1, rv2);
            default: begin
               last = bubble_exp();
               check_out("bubble", last, rv1, rv2);
            end
         endcase
         chk("f_ready", 32'(f_ready), 32'(exp_q.size() < DEPTH));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push1(input bit [31:0] inst, input bit [31:0] pc);
      f_valid = 1; f_inst = inst; f_pc = pc;
      cyc();
      f_valid = 0;
   endtask

   bit [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

   initial begin
      bit [31:0] r;
      rst = 1; stall = 0; flush = 0; f_valid = 0; f_inst = 0; f_pc = 0;
      ovr1_en = 0; ovr1 = 0;
      cyc(3);
      chk("reset.finalI", finalI, 32'h13);
      chk("reset.f_ready", 32'(f_ready), 32'd1);
      rst = 0;
      cyc();

      // add x3,x1,x2: visible two edges after it is presented
      push1(32'h0020_81B3, 32'h100);
      cyc();
      chk("add.d_valid", 32'(d_valid), 32'd1);
      chk("add.rtype", 32'(rtype), 32'd1);
      chk("add.regs", 32'({reg1, reg2, regD}), 32'({5'd1, 5'd2, 5'd3}));
      chk("add.finalpc", finalpc, 32'h100);
      cyc(2);

      // fill under stall: four accepted, fifth refused, then drained in order
      stall = 1;
      for (int i = 0; i < 5; i++) begin
         f_valid = 1; f_inst = 32'h0010_0093 + (32'(i) << 7); f_pc = 32'h200 + 32'(i) * 4;
         cyc();
         if (i == 3) chk("full.f_ready", 32'(f_ready), 32'd0);
      end
      f_valid = 0; stall = 0;
      cyc();
      chk("drain.first_pc", finalpc, 32'h200);
      cyc(5);

      // flush with three queued and a same-cycle push, stall also high
      stall = 1;
      for (int i = 0; i < 3; i++) push1(32'h0000_0013, 32'h300 + 32'(i) * 4);
      flush = 1; f_valid = 1; f_inst = 32'h0020_81B3; f_pc = 32'h400;
      cyc();
      flush = 0; f_valid = 0; stall = 0;
      chk("flush.d_valid", 32'(d_valid), 32'd0);
      chk("flush.finalI", finalI, 32'h13);
      chk("flush.f_ready", 32'(f_ready), 32'd1);
      cyc(3);

      // operand refresh during stall: addi x5,x7,1
      push1(32'h0013_8293, 32'h500);
      cyc();
      stall = 1; ovr1_en = 1; ovr1 = 5;
      cyc();
      ovr1 = 9;
      cyc(2);
      chk("stall.reg1val", reg1val, 32'd9);
      chk("stall.finalI", finalI, 32'h0013_8293);
      stall = 0; ovr1_en = 0;
      cyc(2);

      // beq -8 then auipc back to back
      push1(32'hFE00_0CE3, 32'h600);
      push1(32'h1234_5097, 32'h604);
      chk("beq.imm", imm, 32'hFFFF_FFF8);
      cyc();
      chk("auipc.auipc", 32'(auipc), 32'd1);
      chk("auipc.imm", imm, 32'h1234_5000);
      chk("auipc.regD", 32'(regD), 32'd1);
      cyc(2);

      // unknown opcode then mid-stream reset
      push1(32'h0000_0073, 32'h700);
      cyc();
      chk("ill.illegal", 32'(illegal), 32'd1);
      chk("ill.d_valid", 32'(d_valid), 32'd1);
      stall = 1;
      push1(32'h0020_81B3, 32'h704);
      push1(32'h0020_81B3, 32'h708);
      rst = 1; f_valid = 1; f_inst = 32'h0020_81B3; f_pc = 32'h70C;
      cyc();
      rst = 0; f_valid = 0; stall = 0;
      chk("rst.d_valid", 32'(d_valid), 32'd0);
      chk("rst.f_ready", 32'(f_ready), 32'd1);
      chk("rst.finalI", finalI, 32'h13);
      cyc(3);

      // randomized traffic
      for (int c = 0; c < 500; c++) begin
         r       = $urandom;
         f_inst  = {r[31:7], ops[$urandom_range(0, 9)]};
         f_pc    = $urandom & 32'hFFFF_FFFC;
         f_valid = ($urandom_range(0, 99) < 60);
         stall   = ($urandom_range(0, 99) < 30);
         flush   = ($urandom_range(0, 99) < 5);
         rst     = ($urandom_range(0, 199) < 2);
         cyc();
      end
      f_valid = 0; stall = 0; flush = 0; rst = 0;
      cyc(8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decode_iq.md
DECODE_IQ -- requirements
Module: decode_iq

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter NOP_INST, default 32'h00000013, bubble instruction word.
REQ-003 SHALL have ports: clk in 1 clock; rst in 1 reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have ports: stall in 1 hold decode output; flush in 1 discard queue and output (jal/branch redirect).
REQ-005 SHALL have ports: f_valid in 1, f_inst in 32, f_pc in 32 fetch push; f_ready out 1 queue not full.
REQ-006 SHALL have ports: file_reg1/file_reg2 out 5 regfile read addresses; file_val1/file_val2 in 32 read data.
REQ-007 SHALL have ports: d_valid out 1; rtype, itype, lui, auipc, load, store, branch, jal, jalr, illegal out 1 each (one-hot class).
REQ-008 SHALL have ports: funct3 out 3; imm, finalI, finalpc out 32; reg1, reg2, regD out 5; uses_rs1, uses_rs2 out 1; reg1val, reg2val out 32.

Function
REQ-009 SHALL buffer fetched instructions in an IQ_DEPTH-entry FIFO of {inst, pc}; push when f_valid && f_ready && !flush.
REQ-010 SHALL drive f_ready = (count < IQ_DEPTH), registered count only, no dependence on same-cycle pop.
REQ-011 SHALL pop the head when !stall && !flush && count != 0; push and pop in the same cycle keep count unchanged.
REQ-012 SHALL wrap read/write pointers modulo IQ_DEPTH; count width clog2(IQ_DEPTH+1).
REQ-013 SHALL decode the head combinationally and load all output registers at the popping edge: minimum latency 2 edges from push to d_valid.
REQ-014 SHALL, when !stall && !flush && queue empty, load a bubble: d_valid=0, itype=1, finalI=NOP_INST, all other flags/fields 0.
REQ-015 SHALL, on stall (flush low), hold every output register except reg1val/reg2val, which reload from file_val1/file_val2 each cycle.
REQ-016 SHALL drive file_reg1/file_reg2 from the decoded head when popping, from held reg1/reg2 when stalled, else 0.
REQ-017 SHALL, on flush, empty the queue (count=0, pointers equal), drop any same-cycle push, and load a bubble; flush overrides stall.
REQ-018 SHALL decode opcodes 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
REQ-019 SHALL form imm: I/load/jalr sign-ext inst[31:20]; S sign-ext {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}, sign-extended; U {inst[31:12],12'b0}.
REQ-020 SHALL set uses_rs1 for R/I/load/store/branch/jalr, uses_rs2 for R/store/branch; unused reg fields 0.
REQ-021 SHALL flag any other opcode illegal=1, d_valid=1, other class flags 0, regD=0.
REQ-022 SHALL output funct3=inst[14:12] for all valid instructions, finalI=inst, finalpc=pc.

Reset
REQ-023 SHALL on rst at posedge clk: count/pointers 0, d_valid=0, itype=1, finalI=NOP_INST, all other outputs 0.
REQ-024 SHALL give rst priority over flush, stall and push; an instruction presented during reset is discarded.

Structure
REQ-025 SHALL place opcode constants, NOP_INST default and imm-format decode function in package decode_pkg.
REQ-026 SHALL implement the FIFO as sub-module inst_queue (parameter DEPTH, width 64), instantiated once.

Verification
REQ-027 SHALL cover: push add x3,x1,x2 (0x002081B3, pc 0x100) -> 2 edges later d_valid=1, rtype=1, reg1=1, reg2=2, regD=3, finalpc=0x100.
REQ-028 SHALL cover: push 5 instructions, stall high, IQ_DEPTH=4 -> f_ready=0 after 4th, 5th not accepted, outputs held; drop stall -> order preserved.
REQ-029 SHALL cover: queue with 3 entries, flush pulse with f_valid=1 -> next cycle d_valid=0, finalI=0x00000013, count=0, f_ready=1.
REQ-030 SHALL cover: stall held 3 cycles while file_val1 changes 5->9 -> reg1val=9, other outputs unchanged.
REQ-031 SHALL cover: beq with imm -8 (0xFE000CE3) -> imm=0xFFFFFFF8; auipc 0x12345097 -> auipc=1, imm=0x12345000, regD=1.
REQ-032 SHALL cover: opcode 1110011 -> illegal=1, d_valid=1; rst asserted mid-stream -> next edge bubble, count=0.
